single_argmax_stream: RTL and testbench

SINGLE_ARGMAX_STREAM -- requirements
Module: single_argmax_stream

---
 rtl/single_argmax_stream.sv | 88 ++++++++
 tb/tb_single_argmax_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/single_argmax_stream.sv
// Streaming argmax over IEEE-754 single-precision frames; result is presented one cycle after the last accept.
// The input stalls (in_ready low) while a result is held; out_valid is held until out_ready.
module single_argmax_stream #(
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {FIRST, ACCUM, HOLD} state_t;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LEN);

  state_t         state, state_nxt;
  logic           accept, xfer, at_limit, is_greater;
  logic [IDX_W:0] cnt_nxt;

  // Sign-magnitude ordering: exponent and mantissa compare together as one 31-bit
  // magnitude, with the sense inverted when both operands are negative.
  function automatic logic f32_gt(input logic [31:0] x, input logic [31:0] m);
    if (x[31] != m[31]) return !x[31];
    else if (!x[31])    return x[30:0] > m[30:0];
    else                return x[30:0] < m[30:0];
  endfunction

  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign cnt_nxt    = out_count + 1'b1;
  assign at_limit   = (cnt_nxt == MAX_CNT);
  assign is_greater = f32_gt(in_data, out_max);

  always_ff @(posedge clk) begin
    if (!rstn) state <= FIRST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FIRST:   if (accept) state_nxt = in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && (in_last || at_limit)) state_nxt = HOLD;
      HOLD:    if (xfer) state_nxt = FIRST;
      default: state_nxt = FIRST;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
  end

  // Result registers double as the running accumulator; they only move on accept,
  // so they are naturally frozen while HOLD blocks the input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_max      <= '0;
      out_idx      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (accept) begin
      if (state == FIRST) begin
        out_max      <= in_data;
        out_idx      <= '0;
        out_count    <= (IDX_W+1)'(1);
        out_overflow <= 1'b0;
      end else begin
        if (is_greater) begin
          out_max <= in_data;
          out_idx <= out_count[IDX_W-1:0];
        end
        out_count    <= cnt_nxt;
        out_overflow <= at_limit && !in_last;
      end
    end
  end

endmodule

// File: tb/tb_single_argmax_stream.sv
// Bench for single_argmax_stream (MAX_LEN=4): directed frames with literal results,
// then randomized traffic against a queue-based argmax model.
module tb_single_argmax_stream;
  localparam int ML = 4;
  localparam int IW = $clog2(ML);

  logic          clk, rstn, in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
  logic [31:0]   in_data, out_max;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_count;

  single_argmax_stream #(.MAX_LEN(ML)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
    .out_count(out_count), .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model state
  bit          m_known = 0, m_hold = 0, m_acc = 0;
  logic [31:0] frame[$];
  logic [31:0] e_max;
  int          e_idx, e_cnt;
  bit          e_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Totally ordered unsigned key: larger key <=> larger float under sign-magnitude rules.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  task automatic close_frame(input bit last);
    int best = 0;
    for (int i = 1; i < frame.size(); i++)
      if (fkey(frame[i]) > fkey(frame[best])) best = i;
    e_max  = frame[best];
    e_idx  = best;
    e_cnt  = frame.size();
    e_ovf  = !last;
    m_hold = 1;
    frame.delete();
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model
  // to what the next rising edge must do.
  task automatic cycle(input bit rst, input bit iv, input logic [31:0] d, input bit l, input bit ordy);
    bit xfer;
    @(negedge clk);
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold) begin
        chk("out_max", out_max, e_max);
        chk("out_idx", 32'(out_idx), 32'(e_idx));
        chk("out_count", 32'(out_count), 32'(e_cnt));
        chk("out_overflow", 32'(out_overflow), 32'(e_ovf));
      end
    end
    rstn = !rst; in_valid = iv; in_data = d; in_last = l; out_ready = ordy;
    if (rst) begin
      m_known = 1; m_hold = 0; m_acc = 0; frame.delete();
    end else if (m_known) begin
      m_acc = iv && !m_hold;
      xfer  = m_hold && ordy;
      if (xfer) m_hold = 0;
      if (m_acc) begin
        frame.push_back(d);
        if (l || frame.size() == ML) close_frame(l);
      end
    end
  endtask

  // Literal expectations for a held result, applied to both DUT and model.
  task automatic lit(input string nm, input logic [31:0] mx, input int ix, input int cn, input bit ov);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_max"}, out_max, mx);
    chk({nm, "_idx"}, 32'(out_idx), 32'(ix));
    chk({nm, "_count"}, 32'(out_count), 32'(cn));
    chk({nm, "_ovf"}, 32'(out_overflow), 32'(ov));
    chk({nm, "_model_max"}, e_max, mx);
    chk({nm, "_model_idx"}, 32'(e_idx), 32'(ix));
  endtask

  function automatic logic [31:0] pick_data();
    logic [31:0] tbl[9] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                            32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h80000001};
    if ($urandom_range(0, 1) == 0) return $urandom;
    return tbl[$urandom_range(0, 8)];
  endfunction

  bit          r_iv, r_l, r_rst;
  logic [31:0] r_d;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("rst_max", out_max, 32'h0);
    chk("rst_idx", 32'(out_idx), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    chk("rst_ovf", 32'(out_overflow), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Mixed signs
    cycle(0, 1, 32'h3F800000, 0, 0);
    cycle(0, 1, 32'h40000000, 0, 0);
    cycle(0, 1, 32'hC0400000, 1, 0);
    cycle(0, 0, 0, 0, 1);
    lit("mixed", 32'h40000000, 1, 3, 0);
    // All negative with tie
    cycle(0, 1, 32'hC0400000, 0, 0);
    cycle(0, 1, 32'hBF800000, 0, 0);
    cycle(0, 1, 32'hBF800000, 1, 0);
    cycle(0, 0, 0, 0, 1);
    lit("neg_tie", 32'hBF800000, 1, 3, 0);
    // Signed zeros
    cycle(0, 1, 32'h80000000, 0, 0);
    cycle(0, 1, 32'h00000000, 1, 0);
    cycle(0, 0, 0, 0, 1);
    lit("zeros", 32'h00000000, 1, 2, 0);
    // Single element
    cycle(0, 1, 32'h40000000, 1, 0);
    cycle(0, 0, 0, 0, 1);
    lit("single", 32'h40000000, 0, 1, 0);
    // Last coincides with the length limit
    cycle(0, 1, 32'hBF800000, 0, 0);
    cycle(0, 1, 32'h3F800000, 0, 0);
    cycle(0, 1, 32'h3F800000, 0, 0);
    cycle(0, 1, 32'h00000000, 1, 0);
    cycle(0, 0, 0, 0, 1);
    lit("limit_last", 32'h3F800000, 1, 4, 0);
    // Overflow, then a long stall with the 5th element waiting
    cycle(0, 1, 32'h3F800000, 0, 0);
    cycle(0, 1, 32'h40000000, 0, 0);
    cycle(0, 1, 32'h40400000, 0, 0);
    cycle(0, 1, 32'h40800000, 0, 0);
    cycle(0, 1, 32'h40A00000, 1, 0);
    lit("ovf", 32'h40800000, 3, 4, 1);
    repeat (10) cycle(0, 1, 32'h40A00000, 1, 0);
    lit("ovf_stall", 32'h40800000, 3, 4, 1);
    cycle(0, 1, 32'h40A00000, 1, 1);
    cycle(0, 1, 32'h40A00000, 1, 0);
    cycle(0, 0, 0, 0, 0);
    lit("after_ovf", 32'h40A00000, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    // Reset mid-frame
    cycle(0, 1, 32'h7F000000, 0, 0);
    cycle(0, 1, 32'h7F100000, 0, 0);
    cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'hC0000000, 0, 0);
    cycle(0, 1, 32'h40400000, 0, 0);
    cycle(0, 1, 32'h40400000, 1, 0);
    cycle(0, 0, 0, 0, 0);
    lit("post_rst", 32'h40400000, 1, 3, 0);
    cycle(0, 0, 0, 0, 1);

    // Randomized traffic; a stalled element is held until accepted
    r_iv = 0; r_d = 0; r_l = 0;
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if (!(r_iv && !m_acc)) begin
        r_iv = ($urandom_range(0, 3) != 0);
        r_d  = pick_data();
        r_l  = ($urandom_range(0, 3) == 0);
      end
      cycle(r_rst, r_iv, r_d, r_l, ($urandom_range(0, 2) != 0));
    end
    repeat (3) cycle(0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
